// File: rtl/onehot_encoder_pipe.sv
// Pipelined one-hot to binary encoder: a radix-SPLIT OR tree with one register
// stage per tree level, valid/ready flow control and a multi-hot error flag.
module onehot_encoder_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_vld,
  output logic                       s_rdy,
  input  logic [WIDTH-1:0]           dec_vld,
  output logic                       m_vld,
  input  logic                       m_rdy,
  output logic [$clog2(WIDTH)-1:0]   enc_idx,
  output logic                       enc_vld,
  output logic                       enc_err
);

  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int SPLIT_LOG = $clog2(SPLIT);
  localparam int LEVELS    = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;
  localparam int PAD_W     = SPLIT ** LEVELS;

  if (WIDTH < 2 || SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_param_check
    $error("onehot_encoder_pipe: WIDTH must be >= 2 and SPLIT a power of two >= 2");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Valid never depends on ready; s_rdy depends on m_rdy and stage occupancy
  // only, never on s_vld. Payload is held while m_vld && !m_rdy.

  logic [PAD_W-1:0]  pad_in;
  logic [LEVELS:1]   stg_vld;
  logic [LEVELS:1]   load;

  assign pad_in = PAD_W'(dec_vld);

  // A stage loads when empty or when its content moves on this cycle.
  always_comb begin
    logic adv;
    adv  = m_rdy;
    load = '0;
    for (int k = LEVELS; k >= 1; k--) begin
      load[k] = !stg_vld[k] || adv;
      adv     = load[k];
    end
  end

  assign s_rdy = load[1];
  assign m_vld = stg_vld[LEVELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
    end else begin
      if (load[1]) stg_vld[1] <= s_vld;
      for (int k = 2; k <= LEVELS; k++) begin
        if (load[k]) stg_vld[k] <= stg_vld[k-1];
      end
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    localparam int NODES = SPLIT ** (LEVELS - k);
    localparam int IDX_W = k * SPLIT_LOG;

    logic [NODES-1:0]       vld_q, err_q, vld_d, err_d;
    logic [IDX_W-1:0]       idx_q [NODES];
    logic [IDX_W-1:0]       idx_d [NODES];
    logic [SPLIT_LOG-1:0]   sel   [NODES];
    logic [NODES*SPLIT-1:0] c_vld, c_err;

    // Child position is OR-ed in rather than priority-selected; a second set
    // child flags the node as multi-hot.
    always_comb begin
      for (int i = 0; i < NODES; i++) begin
        vld_d[i] = 1'b0;
        err_d[i] = 1'b0;
        sel[i]   = '0;
        for (int j = 0; j < SPLIT; j++) begin
          err_d[i] = err_d[i] | c_err[i*SPLIT+j];
          if (c_vld[i*SPLIT+j]) begin
            err_d[i] = err_d[i] | vld_d[i];
            vld_d[i] = 1'b1;
            sel[i]   = sel[i] | SPLIT_LOG'(j);
          end
        end
      end
    end

    if (k == 1) begin : g_leaf
      assign c_vld = pad_in;
      assign c_err = '0;
      assign idx_d = sel;
    end else begin : g_inner
      logic [IDX_W-SPLIT_LOG-1:0] c_idx [NODES*SPLIT];

      assign c_vld = g_stage[k-1].vld_q;
      assign c_err = g_stage[k-1].err_q;
      assign c_idx = g_stage[k-1].idx_q;

      always_comb begin
        for (int i = 0; i < NODES; i++) begin
          idx_d[i] = {sel[i], {(IDX_W-SPLIT_LOG){1'b0}}};
          for (int j = 0; j < SPLIT; j++) begin
            idx_d[i] = idx_d[i] | IDX_W'(c_idx[i*SPLIT+j]);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        err_q <= '0;
        for (int i = 0; i < NODES; i++) idx_q[i] <= '0;
      end else if (load[k]) begin
        vld_q <= vld_d;
        err_q <= err_d;
        idx_q <= idx_d;
      end
    end
  end

  // Padding bits are never set, so the root index above WIDTH_LOG is always zero.
  assign enc_idx = g_stage[LEVELS].idx_q[0][WIDTH_LOG-1:0];
  assign enc_vld = g_stage[LEVELS].vld_q[0];
  assign enc_err = g_stage[LEVELS].err_q[0];

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: 32-bit/radix-4 and 5-bit/radix-2 instances
// checked against a popcount/OR-of-indices reference model.
module tb_onehot_encoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_vld, s_rdy, m_vld, m_rdy, enc_vld, enc_err;
  logic [31:0] dec_vld;
  logic [4:0]  enc_idx;

  logic        s5_vld, s5_rdy, m5_vld, m5_rdy, enc5_vld, enc5_err;
  logic [4:0]  s5_dec;
  logic [2:0]  enc5_idx;

  onehot_encoder_pipe #(.WIDTH(32), .SPLIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_vld(s_vld), .s_rdy(s_rdy), .dec_vld(dec_vld),
    .m_vld(m_vld), .m_rdy(m_rdy), .enc_idx(enc_idx), .enc_vld(enc_vld), .enc_err(enc_err)
  );

  onehot_encoder_pipe #(.WIDTH(5), .SPLIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_vld(s5_vld), .s_rdy(s5_rdy), .dec_vld(s5_dec),
    .m_vld(m5_vld), .m_rdy(m5_rdy), .enc_idx(enc5_idx), .enc_vld(enc5_vld), .enc_err(enc5_err)
  );

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp5_q[$];
  logic       held;
  logic [7:0] held_pl;

  logic [31:0] pat   [4] = '{32'h0, (32'd1 << 5) | (32'd1 << 18), 32'h6, 32'h8000_0001};
  logic [4:0]  bstim [4] = '{5'b10000, 5'b00001, 5'b10001, 5'b00000};
  logic [4:0]  bexp  [4] = '{{2'b01, 3'd4}, {2'b01, 3'd0}, {2'b11, 3'd4}, {2'b00, 3'd0}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {err, vld, idx}: idx is the OR of the positions of all set bits.
  function automatic logic [6:0] model(input logic [31:0] x, input int w);
    logic [4:0] idx;
    int cnt;
    idx = '0;
    cnt = 0;
    for (int i = 0; i < w; i++) begin
      if (x[i]) begin
        idx = idx | 5'(i);
        cnt++;
      end
    end
    return {cnt > 1, cnt > 0, idx};
  endfunction

  task automatic tick_a();
    logic [6:0] e;
    #1;
    if (held) check("a_hold_stable", {m_vld, enc_err, enc_vld, enc_idx}, held_pl);
    held    = m_vld && !m_rdy;
    held_pl = {1'b1, enc_err, enc_vld, enc_idx};
    if (m_vld && m_rdy) begin
      if (exp_q.size() == 0) check("a_spurious_out", m_vld, 0);
      else begin
        e = exp_q.pop_front();
        check("a_out", {enc_err, enc_vld, enc_idx}, e);
      end
    end
    if (s_vld && s_rdy) begin
      exp_q.push_back(model(dec_vld, 32));
      n_acc++;
    end
    check("a_inflight_cap", exp_q.size() <= 3, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_a(input int budget);
    s_vld = 1'b0;
    m_rdy = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick_a();
    check("a_drain_empty", exp_q.size(), 0);
  endtask

  task automatic tick_b();
    logic [6:0] e;
    #1;
    if (m5_vld && m5_rdy) begin
      if (exp5_q.size() == 0) check("b_spurious_out", m5_vld, 0);
      else begin
        e = exp5_q.pop_front();
        check("b_out_rand", {enc5_err, enc5_vld, 2'b00, enc5_idx}, e);
      end
    end
    if (s5_vld && s5_rdy) exp5_q.push_back(model({27'd0, s5_dec}, 5));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; s_vld = 1'b0; dec_vld = '0; m_rdy = 1'b1;
    s5_vld = 1'b0; s5_dec = '0; m5_rdy = 1'b1; held = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_m_vld", m_vld, 0);
    check("rst_s_rdy", s_rdy, 1);
    check("rst_payload", {enc_err, enc_vld, enc_idx}, 0);
    check("rst_b_m_vld", m5_vld, 0);
    check("rst_b_s_rdy", s5_rdy, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Bit sweep, unstalled
    for (int n = 0; n < 32; n++) begin
      s_vld = 1'b1;
      dec_vld = 32'd1 << n;
      #1;
      check("sweep_s_rdy", s_rdy, 1);
      check("sweep_m_vld", m_vld, n >= 3);
      tick_a();
    end
    drain_a(10);

    // Zero / multi-hot patterns, then random traffic with random stalls
    for (int n = 0; n < 4; n++) begin
      s_vld = 1'b1;
      dec_vld = pat[n];
      tick_a();
    end
    for (int c = 0; c < 120; c++) begin
      s_vld = ($urandom_range(0, 3) != 0);
      m_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: dec_vld = '0;
        1: dec_vld = 32'd1 << $urandom_range(0, 31);
        2: dec_vld = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        default: dec_vld = $urandom;
      endcase
      tick_a();
    end
    drain_a(20);

    // Backpressure: three fill the pipe, then s_rdy drops
    base = n_acc;
    m_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_vld = 1'b1;
      dec_vld = 32'd1 << (n_acc - base);
      #1;
      check("bp_s_rdy", s_rdy, c < 3);
      tick_a();
    end
    #1;
    check("bp_accepted3", n_acc - base, 3);
    check("bp_m_vld", m_vld, 1);
    check("bp_enc_idx", enc_idx, 0);
    m_rdy = 1'b1;
    for (int c = 0; c < 40 && (n_acc - base) < 10; c++) begin
      s_vld = 1'b1;
      dec_vld = 32'd1 << (n_acc - base);
      tick_a();
    end
    check("bp_accepted10", n_acc - base, 10);
    drain_a(10);

    // Bubble collapse under a stalled output
    m_rdy = 1'b0;
    s_vld = 1'b1;
    dec_vld = 32'd1 << 7;
    #1;
    check("bub_s_rdy_first", s_rdy, 1);
    tick_a();
    s_vld = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("bub_s_rdy_idle", s_rdy, 1);
      tick_a();
    end
    for (int c = 0; c < 2; c++) begin
      s_vld = 1'b1;
      dec_vld = 32'd1 << (8 + c);
      #1;
      check("bub_s_rdy_fill", s_rdy, 1);
      tick_a();
    end
    dec_vld = 32'd1 << 10;
    #1;
    check("bub_s_rdy_full", s_rdy, 0);
    check("bub_m_vld", m_vld, 1);
    tick_a();
    drain_a(10);

    // Asynchronous reset with three items in flight
    m_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_vld = 1'b1;
      dec_vld = 32'd1 << (11 + c);
      tick_a();
    end
    s_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_vld", m_vld, 0);
    check("arst_s_rdy", s_rdy, 1);
    check("arst_payload", {enc_err, enc_vld, enc_idx}, 0);
    exp_q.delete();
    held = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_rdy = 1'b1;
    for (int n = 0; n < 6; n++) begin
      s_vld = (n == 0);
      dec_vld = 32'd1 << 20;
      #1;
      check("arst_latency_m_vld", m_vld, n == 3);
      tick_a();
    end
    drain_a(10);

    // Odd width, radix 2
    for (int n = 0; n < 7; n++) begin
      s5_vld = (n < 4);
      s5_dec = (n < 4) ? bstim[n] : 5'd0;
      #1;
      check("b_s_rdy", s5_rdy, 1);
      check("b_m_vld", m5_vld, n >= 3);
      if (n >= 3) check("b_out_directed", {enc5_err, enc5_vld, enc5_idx}, bexp[n-3]);
      @(posedge clk);
      @(negedge clk);
    end
    for (int c = 0; c < 60; c++) begin
      s5_vld = ($urandom_range(0, 3) != 0);
      m5_rdy = ($urandom_range(0, 2) != 0);
      s5_dec = 5'($urandom_range(0, 31));
      tick_b();
    end
    s5_vld = 1'b0;
    m5_rdy = 1'b1;
    for (int c = 0; c < 10 && exp5_q.size() != 0; c++) tick_b();
    check("b_drain_empty", exp5_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
